// File: rtl/tpu_sequencer.sv
// ----------------------------------------------------------------------------
// tpu_sequencer
//
// Sits between the decode stage and the systolic-array TPU. It forwards
// decoded row-load / accumulator-read strobes to the array buffers, runs a
// matmul across its full feed/compute/drain window, and stalls fetch/decode
// for any TPU command that arrives while a matmul is in flight. It also
// remembers which A/B rows have been loaded since the last matmul. A matmul
// that starts before every A and B row has been loaded sets a sticky error.
//
// Ports
//   clk                   clock
//   rst                   asynchronous active-high reset
//   tpu_start_i           matmul decoded
//   tpu_write_enable_A_i  lam decoded (load A row)
//   tpu_write_enable_B_i  lbm decoded (load B row)
//   tpu_write_enable_C_i  lacc decoded (load accumulator row)
//   racc_i                racc decoded (read accumulator row)
//   row_i                 target row for lam/lbm/lacc/racc
//   flush_i               decode-stage instruction squashed
//   stall_o               hold fetch/decode this cycle
//   a_wr_o/b_wr_o/c_wr_o  forwarded row-write strobes
//   c_rd_o                accumulator row read strobe
//   row_o                 row index to array buffers (0 when nothing forwarded)
//   array_en_o            advance systolic array one step
//   busy_o                matmul in flight
//   done_o                one-cycle matmul-complete pulse
//   operand_err_o         sticky: matmul started with A or B rows incomplete
// ----------------------------------------------------------------------------
module tpu_sequencer #(
    parameter int unsigned DIM   = 8,
    parameter int unsigned ROW_W = $clog2(DIM),
    parameter int unsigned CNT_W = $clog2(3 * DIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tpu_start_i,
    input  logic             tpu_write_enable_A_i,
    input  logic             tpu_write_enable_B_i,
    input  logic             tpu_write_enable_C_i,
    input  logic             racc_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             a_wr_o,
    output logic             b_wr_o,
    output logic             c_wr_o,
    output logic             c_rd_o,
    output logic [ROW_W-1:0] row_o,
    output logic             array_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             operand_err_o
);

    // Feed (DIM) + compute/drain (2*DIM-2) cycles of the systolic array.
    localparam int unsigned MM_CYCLES = 3 * DIM - 2;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(MM_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIM-1:0]   a_mask_q, a_mask_d;
    logic [DIM-1:0]   b_mask_q, b_mask_d;
    logic             operand_err_q, operand_err_d;

    logic             cmd;
    logic             live;

    // A squashed instruction is invisible: it neither stalls nor forwards.
    // Forwarding is also held off while reset is asserted so every output
    // reads 0 during reset regardless of what decode is presenting.
    assign live = ~flush_i & ~rst;
    assign cmd  = live & (tpu_start_i | tpu_write_enable_A_i | tpu_write_enable_B_i |
                          tpu_write_enable_C_i | racc_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            a_mask_q      <= '0;
            b_mask_q      <= '0;
            operand_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a_mask_q      <= a_mask_d;
            b_mask_q      <= b_mask_d;
            operand_err_q <= operand_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        a_mask_d      = a_mask_q;
        b_mask_d      = b_mask_q;
        operand_err_d = operand_err_q;
        stall_o       = 1'b0;
        a_wr_o        = 1'b0;
        b_wr_o        = 1'b0;
        c_wr_o        = 1'b0;
        c_rd_o        = 1'b0;
        row_o         = '0;
        array_en_o    = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            // DONE accepts commands exactly like IDLE; it only adds the
            // completion pulse, and a new start goes straight back to RUN.
            StIdle, StDone: begin
                done_o  = (state_q == StDone);
                state_d = StIdle;

                a_wr_o = live & tpu_write_enable_A_i;
                b_wr_o = live & tpu_write_enable_B_i;
                c_wr_o = live & tpu_write_enable_C_i;
                c_rd_o = live & racc_i;

                if (a_wr_o || b_wr_o || c_wr_o || c_rd_o) begin
                    row_o = row_i;
                end
                if (a_wr_o) begin
                    a_mask_d[row_i] = 1'b1;
                end
                if (b_wr_o) begin
                    b_mask_d[row_i] = 1'b1;
                end

                if (live && tpu_start_i) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    if (!(&a_mask_q) || !(&b_mask_q)) begin
                        operand_err_d = 1'b1;
                    end
                    // Operands are consumed by this matmul; the next one
                    // must reload every row.
                    a_mask_d = '0;
                    b_mask_d = '0;
                end
            end

            StRun: begin
                array_en_o = 1'b1;
                busy_o     = 1'b1;
                // Decode holds the command and re-presents it, so nothing is
                // forwarded and the masks stay untouched.
                stall_o    = cmd;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign operand_err_o = operand_err_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
module tb_tpu_sequencer;

    localparam int DIM   = 4;
    localparam int ROW_W = 2;
    localparam int CNT_W = 4;
    localparam int MM    = 3 * DIM - 2;
    localparam int VW    = 9 + ROW_W;

    logic             clk;
    logic             rst;
    logic             tpu_start_i;
    logic             tpu_write_enable_A_i;
    logic             tpu_write_enable_B_i;
    logic             tpu_write_enable_C_i;
    logic             racc_i;
    logic [ROW_W-1:0] row_i;
    logic             flush_i;
    logic             stall_o;
    logic             a_wr_o;
    logic             b_wr_o;
    logic             c_wr_o;
    logic             c_rd_o;
    logic [ROW_W-1:0] row_o;
    logic             array_en_o;
    logic             busy_o;
    logic             done_o;
    logic             operand_err_o;

    tpu_sequencer #(
        .DIM  (DIM),
        .ROW_W(ROW_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .tpu_start_i         (tpu_start_i),
        .tpu_write_enable_A_i(tpu_write_enable_A_i),
        .tpu_write_enable_B_i(tpu_write_enable_B_i),
        .tpu_write_enable_C_i(tpu_write_enable_C_i),
        .racc_i              (racc_i),
        .row_i               (row_i),
        .flush_i             (flush_i),
        .stall_o             (stall_o),
        .a_wr_o              (a_wr_o),
        .b_wr_o              (b_wr_o),
        .c_wr_o              (c_wr_o),
        .c_rd_o              (c_rd_o),
        .row_o               (row_o),
        .array_en_o          (array_en_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .operand_err_o       (operand_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: per-cycle expected output vectors and expected done cycles.
    logic [VW-1:0] exp_q[$];
    int            done_q[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model state: a run is described only by the cycle its start
    // was accepted; RUN/DONE membership follows from cycle arithmetic.
    int       m_run_start = -1000;
    bit [3:0] m_amask     = '0;
    bit [3:0] m_bmask     = '0;
    bit       m_err       = 1'b0;

    task automatic step(input logic st, input logic a, input logic b, input logic c,
                        input logic r, input logic [ROW_W-1:0] row, input logic fl,
                        input logic rs);
        bit            in_run, in_done, acc, fa, fb, fc, fr, stl;
        logic [ROW_W-1:0] erow;
        @(posedge clk);
        #1;
        cyc++;
        rst                  = rs;
        tpu_start_i          = st;
        tpu_write_enable_A_i = a;
        tpu_write_enable_B_i = b;
        tpu_write_enable_C_i = c;
        racc_i               = r;
        row_i                = row;
        flush_i              = fl;
        if (rs) begin
            exp_q.push_back('0);
            m_run_start = -1000;
            m_amask     = '0;
            m_bmask     = '0;
            m_err       = 1'b0;
            done_q.delete();
            return;
        end
        in_run  = (cyc > m_run_start) && (cyc <= m_run_start + MM);
        in_done = (cyc == m_run_start + MM + 1);
        acc     = !in_run && !fl;
        stl     = in_run && !fl && (st || a || b || c || r);
        fa      = acc && a;
        fb      = acc && b;
        fc      = acc && c;
        fr      = acc && r;
        erow    = (fa || fb || fc || fr) ? row : '0;
        exp_q.push_back({stl, fa, fb, fc, fr, erow, in_run, in_run, in_done, m_err});
        if (fa) m_amask[row] = 1'b1;
        if (fb) m_bmask[row] = 1'b1;
        if (acc && st) begin
            if (m_amask != 4'hF || m_bmask != 4'hF) m_err = 1'b1;
            m_amask     = '0;
            m_bmask     = '0;
            m_run_start = cyc;
            done_q.push_back(cyc + MM + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load_all(input bit skip_b3);
        for (int i = 0; i < DIM; i++) step(0, 1, 0, 0, 0, ROW_W'(i), 0, 0);
        for (int i = 0; i < DIM; i++) begin
            if (!(skip_b3 && i == DIM - 1)) step(0, 0, 1, 0, 0, ROW_W'(i), 0, 0);
        end
    endtask

    task automatic matmul();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        logic [VW-1:0] act, e;
        int            dc;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {stall_o, a_wr_o, b_wr_o, c_wr_o, c_rd_o, row_o, array_en_o, busy_o,
                   done_o, operand_err_o};
            checks++;
            if (act !== e) begin
                fails++;
                $display("FAIL outputs cycle %0d: got %b required %b", cyc, act, e);
            end
        end
        if (done_o === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                fails++;
                $display("FAIL done_pulse cycle %0d: got unexpected pulse, required none", cyc);
            end else begin
                dc = done_q.pop_front();
                if (dc != cyc) begin
                    fails++;
                    $display("FAIL done_time: got cycle %0d required cycle %0d", cyc, dc);
                end
            end
        end
    end

    initial begin
        rst                  = 1'b1;
        tpu_start_i          = 1'b0;
        tpu_write_enable_A_i = 1'b0;
        tpu_write_enable_B_i = 1'b0;
        tpu_write_enable_C_i = 1'b0;
        racc_i               = 1'b0;
        row_i                = '0;
        flush_i              = 1'b0;

        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Clean matmul.
        load_all(0);
        matmul();
        idle(13);

        // B row 3 missing, then a clean matmul: error must stay set.
        load_all(1);
        matmul();
        idle(12);
        load_all(0);
        matmul();
        idle(12);

        // racc row 2 held from RUN cycle 3 until it is accepted in DONE.
        matmul();
        idle(2);
        for (int i = 0; i < MM - 2 + 1; i++) step(0, 0, 0, 0, 1, 2'd2, 0, 0);
        idle(2);

        // Flushed lam during RUN: no stall, no forward, no mask update.
        load_all(0);
        matmul();
        idle(2);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, ROW_W'(i), 1, 0);
        idle(MM);

        // Back-to-back matmul presented in the DONE cycle.
        load_all(0);
        matmul();
        idle(MM);
        matmul();
        idle(13);

        // Reset at RUN cycle 5 aborts the run; the next matmul has no operands.
        load_all(0);
        matmul();
        idle(4);
        step(0, 1, 1, 0, 1, 2'd1, 0, 1);
        idle(1);
        matmul();
        idle(13);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            int k;
            k = $urandom_range(0, 15);
            step(k == 0, k >= 1 && k <= 4, k >= 5 && k <= 8, k == 9, k == 10,
                 ROW_W'($urandom_range(0, DIM - 1)), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 299) == 0);
        end
        idle(MM + 4);
        @(negedge clk);
        #1;

        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL output_drain: got %0d pending, required 0", exp_q.size());
        end
        checks++;
        if (done_q.size() != 0) begin
            fails++;
            $display("FAIL done_drain: got %0d missing pulses, required 0", done_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tpu_sequencer.md
Name: tpu_sequencer

Overview:
- Sits between the decode stage and the systolic-array TPU.
- Takes the decoded TPU strobes (matmul start, A/B/C row writes, accumulator read) and sequences matmul over the full feed/compute/drain window.
- Forwards row-load strobes to the array buffers and stalls the pipeline on any TPU command issued while a matmul is in flight.
- Tracks which A/B rows are loaded and flags matmuls issued on incomplete operands.

Parameters:
- DIM, 8: systolic array dimension (rows = columns = DIM).
- ROW_W, $clog2(DIM): row index width.
- CNT_W, $clog2(3*DIM): run counter width.
- MM_CYCLES (localparam), 3*DIM-2: matmul run length in cycles.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- tpu_start_i  in  1  matmul decoded
- tpu_write_enable_A_i  in  1  lam decoded
- tpu_write_enable_B_i  in  1  lbm decoded
- tpu_write_enable_C_i  in  1  lacc decoded
- racc_i  in  1  racc decoded
- row_i  in  ROW_W  target row for lam/lbm/lacc/racc
- flush_i  in  1  decode-stage instruction squashed (branch/jump)
- stall_o  out  1  hold fetch/decode this cycle
- a_wr_o / b_wr_o / c_wr_o  out  1 each  forwarded row-write strobes
- c_rd_o  out  1  accumulator row read strobe
- row_o  out  ROW_W  row index to array buffers
- array_en_o  out  1  advance systolic array one step
- busy_o  out  1  matmul in flight
- done_o  out  1  one-cycle matmul-complete pulse
- operand_err_o  out  1  sticky: matmul started with A or B rows incomplete

Behaviour:
- Reset (async, active-high):
  - state=IDLE, cnt=0, a_mask=0, b_mask=0.
  - All outputs 0; row_o=0.
  - Reset mid-RUN aborts the operation with no done_o pulse.
- cmd = any of start/A/B/C/racc inputs, qualified by ~flush_i. At most one strobe is high per cycle; decode guarantees this.
- States:
  - IDLE:
    - stall_o=0.
    - A/B/C/racc strobes pass to a_wr_o/b_wr_o/c_wr_o/c_rd_o in the same cycle (combinational); row_o=row_i.
    - a_wr_o sets a_mask[row_i]; b_wr_o sets b_mask[row_i].
    - tpu_start_i (not flushed) -> RUN next cycle, cnt=0. The start cycle itself is not stalled.
    - If a_mask or b_mask is not all-ones at start, operand_err_o sets (sticky until rst).
    - Both masks clear on the transition to RUN.
  - RUN:
    - array_en_o=1, busy_o=1, cnt increments each cycle.
    - At cnt==MM_CYCLES-1 -> DONE next cycle.
    - Any cmd in RUN -> stall_o=1 (combinational). No strobe is forwarded, masks are unchanged, and decode re-presents the command.
    - A flushed command never stalls.
  - DONE:
    - done_o=1 for exactly one cycle, busy_o=0, array_en_o=0.
    - Commands are accepted as in IDLE, including a new start, which goes DONE -> RUN directly.
    - Otherwise -> IDLE.
- Latency: start accepted in cycle T; array_en_o high T+1..T+MM_CYCLES; done_o at T+MM_CYCLES+1.
- Command stalled in the last RUN cycle: forwarded in the DONE cycle.
- A re-load of an already-set mask row is legal and stays set.
- row_o holds row_i whenever a strobe is forwarded, and 0 otherwise.
- stall_o never depends on its own registered value (no combinational loop); it depends on state and inputs only.

Test Plan:
- DIM=4: lam rows 0..3, lbm rows 0..3, then matmul -> array_en_o high exactly 10 cycles; done_o one pulse 11 cycles after start; operand_err_o=0.
- matmul with only rows 0..2 of B loaded -> operand_err_o rises the cycle after start and stays 1 through a second clean matmul.
- racc row 2 issued on RUN cycle 3 and held -> stall_o=1 every remaining RUN cycle, c_rd_o=0; in DONE, c_rd_o=1, row_o=2, stall_o=0.
- lam with flush_i=1 during RUN -> stall_o=0, a_wr_o=0, a_mask unchanged.
- Back-to-back matmul presented in DONE -> no IDLE cycle, second run of 10 array_en_o cycles, two done_o pulses 11 cycles apart.
- rst asserted at RUN cycle 5 -> all outputs 0 immediately; no done_o pulse; masks 0; next matmul sets operand_err_o.
